// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU priority, host starvation guard, one read in flight.
// Optional host lock mode under DMEM_ARB_HOST_LOCK_EN.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic [DATA_W-1:0] cpu_rd,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wd,
  input  logic              host_lock,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              host_owner
);

  localparam int CW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    ARB,
    CPU_RESP
`ifdef DMEM_ARB_HOST_LOCK_EN
    , LOCK
`endif
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   starve_q;
  logic            cpu_rv_q;
  logic            host_rv_q;
  logic            host_owner_q;

  logic            cpu_gnt;
  logic            host_gnt;
  logic            forced;
  logic            in_resp;

`ifndef DMEM_ARB_HOST_LOCK_EN
  logic unused_lock;
  assign unused_lock = host_lock;
`endif

  assign forced  = (starve_q == SMAX) && host_valid;
  assign in_resp = (state_q == CPU_RESP);

  // Outside ARB the slot belongs to the host alone.
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (state_q == ARB) begin
      cpu_gnt  = cpu_req && !forced;
      host_gnt = host_valid && !cpu_gnt;
    end else begin
      host_gnt = host_valid;
    end
  end

  assign cpu_stall = !in_resp && cpu_req && !(cpu_gnt && cpu_we);
  assign host_ready = host_gnt;

  always_comb begin
    mem_en   = cpu_gnt || host_gnt;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (cpu_gnt) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_wd   = cpu_wd;
    end else if (host_gnt) begin
      mem_we   = host_we;
      mem_addr = host_addr;
      mem_wd   = host_wd;
    end
  end

  assign cpu_rvalid  = cpu_rv_q;
  assign cpu_rd      = cpu_rv_q ? mem_rd : '0;
  assign host_rvalid = host_rv_q;
  assign host_rdata  = host_rv_q ? mem_rd : '0;
  assign host_owner  = host_owner_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB;
      starve_q     <= '0;
      cpu_rv_q     <= 1'b0;
      host_rv_q    <= 1'b0;
      host_owner_q <= 1'b0;
    end else begin
      cpu_rv_q     <= cpu_gnt && !cpu_we;
      host_rv_q    <= host_gnt && !host_we;
      host_owner_q <= host_gnt;
      if (host_gnt)
        starve_q <= '0;
      else if (host_valid && starve_q != SMAX)
        starve_q <= starve_q + 1'b1;
      case (state_q)
        ARB: begin
          if (cpu_gnt && !cpu_we)
            state_q <= CPU_RESP;
`ifdef DMEM_ARB_HOST_LOCK_EN
          else if (host_gnt && host_lock)
            state_q <= LOCK;
`endif
          else
            state_q <= ARB;
        end
        CPU_RESP: begin
`ifdef DMEM_ARB_HOST_LOCK_EN
          if (host_gnt && host_lock)
            state_q <= LOCK;
          else
`endif
            state_q <= ARB;
        end
`ifdef DMEM_ARB_HOST_LOCK_EN
        LOCK: begin
          if (!host_lock)
            state_q <= ARB;
        end
`endif
        default: state_q <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed plan steps then random traffic
// against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int SM = 4;

  logic        clk;
  logic        rst;
  logic        creq, cwe, hv, hwe, hlk;
  logic [31:0] caddr, cwd, haddr, hwd;
  logic [31:0] cpu_rd, host_rdata, mem_addr, mem_wd;
  logic [31:0] mem_rd;
  logic        cpu_rvalid, cpu_stall, host_ready, host_rvalid;
  logic        mem_en, mem_we, host_owner;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(creq), .cpu_we(cwe), .cpu_addr(caddr), .cpu_wd(cwd),
    .cpu_rd(cpu_rd), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
    .host_valid(hv), .host_ready(host_ready), .host_we(hwe),
    .host_addr(haddr), .host_wd(hwd), .host_lock(hlk),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .host_owner(host_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory macro stand-in
  logic [31:0] env_mem [256] = '{default: 32'h0};
  initial mem_rd = 32'h0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) env_mem[mem_addr[9:2]] <= mem_wd;
      else        mem_rd <= env_mem[mem_addr[9:2]];
    end
  end

  int n_err = 0;
  int n_checks = 0;

  // Reference model: what each party owns and what data must return
  logic [31:0] ref_mem [256] = '{default: 32'h0};
  int          m_starve;
  bit          m_resp, m_hret, m_lock, m_owner;
  bit          m_cg, m_hg;
  logic [31:0] m_cdata, m_hdata;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_starve = 0;
    m_resp = 0;
    m_hret = 0;
    m_lock = 0;
    m_owner = 0;
  endtask

  task automatic set_in(input logic cr, input logic cw, input logic [31:0] ca,
                        input logic [31:0] cd, input logic h, input logic hw,
                        input logic [31:0] ha, input logic [31:0] hd,
                        input logic hl);
    creq = cr; cwe = cw; caddr = ca; cwd = cd;
    hv = h; hwe = hw; haddr = ha; hwd = hd; hlk = hl;
  endtask

  task automatic sample();
    logic        ewe;
    logic [31:0] ea, ed;
    @(negedge clk);
    if (m_lock || m_resp) begin
      m_cg = 0;
      m_hg = hv;
    end else begin
      m_cg = creq && !(m_starve == SM && hv);
      m_hg = hv && !m_cg;
    end
    ewe = m_cg ? cwe : (m_hg ? hwe : 1'b0);
    ea  = m_cg ? caddr : (m_hg ? haddr : 32'h0);
    ed  = m_cg ? cwd : (m_hg ? hwd : 32'h0);
    chk("host_ready", {31'b0, host_ready}, {31'b0, m_hg});
    chk("cpu_stall", {31'b0, cpu_stall},
        {31'b0, !m_resp && creq && !(m_cg && cwe)});
    chk("mem_en", {31'b0, mem_en}, {31'b0, m_cg || m_hg});
    chk("mem_we", {31'b0, mem_we}, {31'b0, ewe});
    chk("mem_addr", mem_addr, ea);
    chk("mem_wd", mem_wd, ed);
    chk("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, m_resp});
    if (m_resp) chk("cpu_rd", cpu_rd, m_cdata);
    chk("host_rvalid", {31'b0, host_rvalid}, {31'b0, m_hret});
    if (m_hret) chk("host_rdata", host_rdata, m_hdata);
    chk("host_owner", {31'b0, host_owner}, {31'b0, m_owner});
  endtask

  task automatic advance();
    bit nresp, nhret;
    @(posedge clk);
    nresp = 0;
    nhret = 0;
    m_owner = m_hg;
    if (m_cg) begin
      if (cwe) ref_mem[caddr[9:2]] = cwd;
      else begin nresp = 1; m_cdata = ref_mem[caddr[9:2]]; end
    end
    if (m_hg) begin
      if (hwe) ref_mem[haddr[9:2]] = hwd;
      else begin nhret = 1; m_hdata = ref_mem[haddr[9:2]]; end
    end
    if (m_hg) m_starve = 0;
    else if (hv && m_starve < SM) m_starve++;
`ifdef DMEM_ARB_HOST_LOCK_EN
    m_lock = m_lock ? hlk : (m_hg && hlk);
`endif
    m_resp = nresp;
    m_hret = nhret;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    m_cg = 0; m_hg = 0;
    m_cdata = 0; m_hdata = 0;
    @(negedge clk);
    chk("rst_cpu_stall", {31'b0, cpu_stall}, 32'h0);
    chk("rst_host_ready", {31'b0, host_ready}, 32'h0);
    chk("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
    chk("rst_host_rvalid", {31'b0, host_rvalid}, 32'h0);
    chk("rst_host_owner", {31'b0, host_owner}, 32'h0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    // CPU store then load of the same word
    set_in(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    sample();
    chk("st_stall", {31'b0, cpu_stall}, 32'h0);
    advance();
    set_in(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    sample();
    chk("ld_stall", {31'b0, cpu_stall}, 32'h1);
    advance();
    sample();
    chk("ld_rvalid", {31'b0, cpu_rvalid}, 32'h1);
    chk("ld_data", cpu_rd, 32'hDEADBEEF);
    chk("ld_resp_stall", {31'b0, cpu_stall}, 32'h0);
    advance();

    // Host write then read with CPU idle
    set_in(0, 0, 0, 0, 1, 1, 32'h20, 32'h5, 0);
    sample();
    chk("hw_ready", {31'b0, host_ready}, 32'h1);
    advance();
    set_in(0, 0, 0, 0, 1, 0, 32'h20, 0, 0);
    sample();
    chk("hr_ready", {31'b0, host_ready}, 32'h1);
    advance();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("hr_rvalid", {31'b0, host_rvalid}, 32'h1);
    chk("hr_data", host_rdata, 32'h5);
    advance();

    // Starvation: host denied SM cycles then forced through
    for (int i = 0; i < SM + 2; i++) begin
      set_in(1, 1, 32'h40 + 4 * i, 32'h100 + i, 1, 1, 32'h80, 32'h77, 0);
      sample();
      chk("starve_ready", {31'b0, host_ready}, {31'b0, i == SM});
      chk("starve_stall", {31'b0, cpu_stall}, {31'b0, i == SM});
      advance();
    end

    // Simultaneous CPU load and host read
    set_in(1, 0, 32'h10, 0, 1, 0, 32'h20, 0, 0);
    sample();
    chk("dual_cpu_first", {31'b0, host_ready}, 32'h0);
    advance();
    sample();
    chk("dual_host_in_resp", {31'b0, host_ready}, 32'h1);
    chk("dual_cpu_data", cpu_rd, 32'hDEADBEEF);
    advance();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("dual_host_data", host_rdata, 32'h5);
    advance();

    // Reset while a CPU load is returning
    set_in(1, 0, 32'h10, 0, 1, 0, 32'h20, 0, 0);
    sample();
    advance();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    sample();
    chk("midrst_cpu_rv", {31'b0, cpu_rvalid}, 32'h0);
    advance();
    rst = 1'b1;
    sample();
    chk("postrst_cpu_rv", {31'b0, cpu_rvalid}, 32'h0);
    chk("postrst_host_rv", {31'b0, host_rvalid}, 32'h0);
    advance();
    set_in(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    sample();
    chk("postrst_arb_grant", {31'b0, mem_en}, 32'h1);
    advance();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    advance();

`ifdef DMEM_ARB_HOST_LOCK_EN
    for (int i = 0; i < 3; i++) begin
      set_in(i != 0, 1, 32'h90, 32'h9, 1, 1, 32'hA0 + 4 * i, 32'h30 + i, 1);
      sample();
      chk("lock_ready", {31'b0, host_ready}, 32'h1);
      if (i != 0) chk("lock_stall", {31'b0, cpu_stall}, 32'h1);
      advance();
    end
    set_in(1, 1, 32'h90, 32'h9, 0, 0, 0, 0, 0);
    sample();
    chk("unlock_stall", {31'b0, cpu_stall}, 32'h1);
    advance();
    sample();
    chk("unlock_cpu_grant", {31'b0, cpu_stall}, 32'h0);
    chk("unlock_mem_en", {31'b0, mem_en}, 32'h1);
    advance();
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 9) < 8, 1'($urandom),
             {22'b0, 8'($urandom), 2'b0}, $urandom,
             $urandom_range(0, 9) < 6, 1'($urandom),
             {22'b0, 8'($urandom_range(0, 15)), 2'b0}, $urandom,
             $urandom_range(0, 3) == 0);
      sample();
      advance();
    end

    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    advance();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
